// File: rtl/behavioural.sv
// Registered two-operand bitwise gate unit: eight logic results captured together
// on each valid input sample and held between samples.
module behavioural #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_,
  output logic [WIDTH-1:0] or_,
  output logic [WIDTH-1:0] not_a,
  output logic [WIDTH-1:0] not_b,
  output logic [WIDTH-1:0] nand_,
  output logic [WIDTH-1:0] nor_,
  output logic [WIDTH-1:0] xor_,
  output logic [WIDTH-1:0] xnor_
);

  logic             out_valid_q;
  logic [WIDTH-1:0] and_d,   and_q;
  logic [WIDTH-1:0] or_d,    or_q;
  logic [WIDTH-1:0] not_a_d, not_a_q;
  logic [WIDTH-1:0] not_b_d, not_b_q;
  logic [WIDTH-1:0] nand_d,  nand_q;
  logic [WIDTH-1:0] nor_d,   nor_q;
  logic [WIDTH-1:0] xor_d,   xor_q;
  logic [WIDTH-1:0] xnor_d,  xnor_q;

  // Hold by default; operands only reach the registers on a valid sample,
  // so unknown operands while idle never propagate.
  always_comb begin
    and_d   = and_q;
    or_d    = or_q;
    not_a_d = not_a_q;
    not_b_d = not_b_q;
    nand_d  = nand_q;
    nor_d   = nor_q;
    xor_d   = xor_q;
    xnor_d  = xnor_q;
    if (in_valid) begin
      and_d   = a & b;
      or_d    = a | b;
      not_a_d = ~a;
      not_b_d = ~b;
      nand_d  = ~(a & b);
      nor_d   = ~(a | b);
      xor_d   = a ^ b;
      xnor_d  = ~(a ^ b);
    end
  end

  // Reset clears every result, including the inverting ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      and_q       <= '0;
      or_q        <= '0;
      not_a_q     <= '0;
      not_b_q     <= '0;
      nand_q      <= '0;
      nor_q       <= '0;
      xor_q       <= '0;
      xnor_q      <= '0;
    end else begin
      out_valid_q <= in_valid;
      and_q       <= and_d;
      or_q        <= or_d;
      not_a_q     <= not_a_d;
      not_b_q     <= not_b_d;
      nand_q      <= nand_d;
      nor_q       <= nor_d;
      xor_q       <= xor_d;
      xnor_q      <= xnor_d;
    end
  end

  assign out_valid = out_valid_q;
  assign and_      = and_q;
  assign or_       = or_q;
  assign not_a     = not_a_q;
  assign not_b     = not_b_q;
  assign nand_     = nand_q;
  assign nor_      = nor_q;
  assign xor_      = xor_q;
  assign xnor_     = xnor_q;

endmodule

// File: tb/tb_behavioural.sv
// Directed and random checks of the gate unit at WIDTH = 1 and WIDTH = 8.
module tb_behavioural;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Hand-written truth table indexed by {a,b}: and,or,not_a,not_b,nand,nor,xor,xnor
  logic [7:0] tt [4] = '{8'b00111101, 8'b01101010, 8'b01011010, 8'b11000001};

  logic       iv1, a1, b1, ov1;
  logic       and1, or1, na1, nb1, nand1, nor1, xor1, xnor1;
  logic       iv8, ov8;
  logic [7:0] a8, b8;
  logic [7:0] and8, or8, na8, nb8, nand8, nor8, xor8, xnor8;

  logic [7:0]  out1;
  logic [63:0] out8;
  assign out1 = {and1, or1, na1, nb1, nand1, nor1, xor1, xnor1};
  assign out8 = {and8, or8, na8, nb8, nand8, nor8, xor8, xnor8};

  behavioural #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1), .out_valid(ov1),
    .and_(and1), .or_(or1), .not_a(na1), .not_b(nb1),
    .nand_(nand1), .nor_(nor1), .xor_(xor1), .xnor_(xnor1)
  );

  behavioural #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .a(a8), .b(b8), .out_valid(ov8),
    .and_(and8), .or_(or8), .not_a(na8), .not_b(nb8),
    .nand_(nand8), .nor_(nor8), .xor_(xor8), .xnor_(xnor8)
  );

  // Expected 8-bit results built bit by bit from the truth table.
  function automatic logic [63:0] gold8(input logic [7:0] av, input logic [7:0] bv);
    logic [63:0] r;
    logic [7:0]  row;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      row = tt[{av[i], bv[i]}];
      for (int j = 0; j < 8; j++) r[j*8+i] = row[j];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    tick();
    tests_run++;
    if (out1 !== 8'h00 || ov1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_w1: got out=%b ov=%b, want out=00000000 ov=0", out1, ov1);
    end
    tests_run++;
    if (out8 !== 64'h0 || ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_w8: got out=%h ov=%b, want 0 ov=0", out8, ov8);
    end
    // First capture after release, then async assertion mid-cycle.
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (out1 !== 8'b11000001 || ov1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_capture: got out=%b ov=%b, want 11000001 ov=1", out1, ov1);
    end
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out1 !== 8'h00 || ov1 !== 1'b0 || out8 !== 64'h0 || ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got out1=%b ov1=%b out8=%h ov8=%b, want all 0",
               out1, ov1, out8, ov8);
    end
    tick();
    rst_n = 1'b1;
    iv1 = 1'b0;
    iv8 = 1'b0;
    tick();
  endtask

  task automatic test_truth_table();
    for (int i = 0; i < 4; i++) begin
      iv1 = 1'b1;
      {a1, b1} = 2'(i);
      tick();
      tests_run++;
      if (out1 !== tt[i] || ov1 !== 1'b1) begin
        tests_failed++;
        $display("FAIL truth_%0d: got out=%b ov=%b, want out=%b ov=1", i, out1, ov1, tt[i]);
      end
    end
    iv1 = 1'b0;
  endtask

  task automatic test_hold();
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
    tick();
    iv1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin a1 = 1'b0; b1 = 1'b1; end
        1: begin a1 = 1'bx; b1 = 1'bx; end
        2: begin a1 = 1'b1; b1 = 1'b1; end
        default: begin a1 = 1'b0; b1 = 1'bx; end
      endcase
      tick();
      tests_run++;
      if (out1 !== 8'b01011010 || ov1 !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_%0d: got out=%b ov=%b, want 01011010 ov=0", i, out1, ov1);
      end
    end
  endtask

  task automatic test_bitwise();
    iv8 = 1'b1; a8 = 8'hF0; b8 = 8'hCC;
    tick();
    iv8 = 1'b0; a8 = 8'hxx; b8 = 8'hxx;
    tests_run++;
    if (out8 !== 64'hC0FC0F333F033CC3 || ov8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL bitwise_w8: got out=%h ov=%b, want c0fc0f333f033cc3 ov=1", out8, ov8);
    end
    tick();
    tests_run++;
    if (out8 !== 64'hC0FC0F333F033CC3 || ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL bitwise_hold: got out=%h ov=%b, want c0fc0f333f033cc3 ov=0", out8, ov8);
    end
  endtask

  task automatic test_reset_midstream();
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    tick();
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out8 !== 64'h0 || ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_clear: got out=%h ov=%b, want 0 ov=0", out8, ov8);
    end
    tick();
    tests_run++;
    if (out8 !== 64'h0 || ov8 !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_no_pulse: got out=%h ov=%b, want 0 ov=0", out8, ov8);
    end
    rst_n = 1'b1;
    a8 = 8'h5A; b8 = 8'h0F;
    tick();
    iv8 = 1'b0;
    tests_run++;
    if (out8 !== 64'h0A5FA5F0F5A055AA || ov8 !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_recover: got out=%h ov=%b, want 0a5fa5f0f5a055aa ov=1", out8, ov8);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp8;
    logic [7:0]  exp1;
    logic        eov8, eov1, cap8;
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    exp8 = '0; exp1 = '0; eov8 = 1'b0; eov1 = 1'b0; cap8 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      iv8 = 1'($urandom_range(0, 1));
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      iv1 = 1'($urandom_range(0, 1));
      a1  = 1'($urandom);
      b1  = 1'($urandom);
      eov8 = iv8;
      eov1 = iv1;
      if (iv8) begin exp8 = gold8(a8, b8); cap8 = 1'b1; end
      if (iv1) exp1 = tt[{a1, b1}];
      tick();
      tests_run++;
      if (out8 !== exp8 || ov8 !== eov8) begin
        tests_failed++;
        $display("FAIL rand_w8 #%0d: got out=%h ov=%b, want out=%h ov=%b", n, out8, ov8, exp8, eov8);
      end
      tests_run++;
      if (out1 !== exp1 || ov1 !== eov1) begin
        tests_failed++;
        $display("FAIL rand_w1 #%0d: got out=%b ov=%b, want out=%b ov=%b", n, out1, ov1, exp1, eov1);
      end
      if (cap8) begin
        tests_run++;
        if (nand8 !== ~and8 || nor8 !== ~or8 || xnor8 !== ~xor8 || xor8 !== (or8 & nand8)) begin
          tests_failed++;
          $display("FAIL rand_ident #%0d: got and=%h or=%h nand=%h nor=%h xor=%h xnor=%h, want identities",
                   n, and8, or8, nand8, nor8, xor8, xnor8);
        end
      end
    end
    iv1 = 1'b0;
    iv8 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    iv1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0;
    test_reset();
    test_truth_table();
    test_hold();
    test_bitwise();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/behavioural.md
# behavioural

Two-operand bitwise logic-gate unit producing registered AND, OR, NOT-A, NOT-B, NAND, NOR, XOR and XNOR of inputs `a` and `b`. It is a leaf block used as a reusable primitive-gate stage and as a bring-up and verification vehicle for the digital-logic library. All eight results update together one clock after a valid input sample and are held otherwise.

## Interface

**Parameters**

- `WIDTH`, default 1: operand and result width in bits. Every operation is bitwise. Legal range is 1 to 64.

**Ports**

- One clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk`, input, 1 bit: rising-edge clock.
- `rst_n`, input, 1 bit: asynchronous active-low reset.
- `in_valid`, input, 1 bit: `a` and `b` are sampled on a rising edge while this is high.
- `a`, input, `WIDTH` bits: operand A.
- `b`, input, `WIDTH` bits: operand B.
- `out_valid`, output, 1 bit: high for exactly one cycle after each accepted sample.
- `and_`, output, `WIDTH` bits: a & b.
- `or_`, output, `WIDTH` bits: a | b.
- `not_a`, output, `WIDTH` bits: ~a.
- `not_b`, output, `WIDTH` bits: ~b.
- `nand_`, output, `WIDTH` bits: ~(a & b).
- `nor_`, output, `WIDTH` bits: ~(a | b).
- `xor_`, output, `WIDTH` bits: a ^ b.
- `xnor_`, output, `WIDTH` bits: ~(a ^ b).
- Positional port order: `clk`, `rst_n`, `in_valid`, `a`, `b`, `out_valid`, `and_`, `or_`, `not_a`, `not_b`, `nand_`, `nor_`, `xor_`, `xnor_`.

## Operation

- Results are computed combinationally from `a` and `b`. All eight are captured into output registers on the same rising edge of `clk` when `in_valid` = 1.
- When `in_valid` = 0, all eight result outputs hold their last captured values.
- `out_valid` is registered: it equals `in_valid` delayed by one cycle.
- Bit i of each result depends only on bit i of `a` and `b`. There are no carries and no cross-bit interaction.
- The following identities hold at every cycle after the first capture:
  - `nand_` = ~`and_`
  - `nor_` = ~`or_`
  - `xnor_` = ~`xor_`
  - `xor_` = `or_` & `nand_`
- There is no internal state beyond the output registers and `out_valid`. There is no state machine.
- X on `a` or `b` while `in_valid` = 0 must not affect any output.

## Timing

- Latency: 1 clock from the sampling edge to the new results and `out_valid` = 1.
- Throughput: one sample per clock. Back-to-back `in_valid` produces back-to-back results.
- Reset: on `rst_n` = 0, all outputs go asynchronously to 0 without waiting for a clock edge. This includes `xnor_`, `nand_`, `nor_`, `not_a` and `not_b`, which are 0 during reset even though they would be 1 for a = b = 0.
- Reset release: the first capture happens on the first rising edge of `clk` at which `rst_n` = 1 and `in_valid` = 1.
- Reset asserted mid-stream: the in-flight result is discarded, `out_valid` drops immediately, and no result is produced for the sample presented in the reset cycle.
- Inputs must meet setup and hold to `clk`. There are no combinational paths from input to output.

## Test plan

- **Reset:** `rst_n` = 0 with a = b = 1 and `in_valid` = 1 → all outputs 0, including `xnor_` and `nand_`. Asynchronous assertion between clock edges clears outputs within the same cycle.
- **Truth table, WIDTH = 1:** drive (a,b) = 00, 01, 10, 11 on consecutive cycles with `in_valid` = 1 → one cycle later, in the order and, or, not_a, not_b, nand, nor, xor, xnor:
  - 00 → 0,0,1,1,1,1,0,1
  - 01 → 0,1,1,0,1,0,1,0
  - 10 → 0,1,0,1,1,0,1,0
  - 11 → 1,1,0,0,0,0,0,1
  - `out_valid` = 1 on each of the four result cycles.
- **Hold:** capture a = 1, b = 0, then drop `in_valid` and toggle a/b, including driving X → outputs stay at 0,1,0,1,1,0,1,0 and `out_valid` = 0.
- **Bitwise, WIDTH = 8:** a = 0xF0, b = 0xCC → and_ = 0xC0, or_ = 0xFC, not_a = 0x0F, not_b = 0x33, nand_ = 0x3F, nor_ = 0x03, xor_ = 0x3C, xnor_ = 0xC3.
- **Reset mid-stream:** assert `rst_n` = 0 in the cycle after sampling a = b = 1 → outputs go to 0 at once, `out_valid` never pulses for that sample, and the next valid sample after release produces correct results with 1-cycle latency.
- **Random:** 1000 random cycles with random a, b and `in_valid` → every result matches a delayed golden model, and the identities in Operation hold on every cycle.
